// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the issue handshake
// toward the U-type execute stage and its next-PC command.
interface fetch_unit_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned IMM_W = 20;
  localparam int unsigned RD_W  = 5;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_data;
  logic [OP_W-1:0]   op;
  logic [IMM_W-1:0]  in;
  logic [RD_W-1:0]   rd;
  logic [XLEN-1:0]   pcvalue;
  logic              valid;
  logic              ready;
  logic [1:0]        pcop;
  logic [XLEN-1:0]   target;
  logic              fetch_err;

  modport master (
    output imem_req, imem_addr, op, in, rd, pcvalue, valid, fetch_err,
    input  imem_ack, imem_data, ready, pcop, target
  );

  modport slave (
    input  imem_req, imem_addr, op, in, rd, pcvalue, valid, fetch_err,
    output imem_ack, imem_data, ready, pcop, target
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: IDLE -> FETCH -> ISSUE -> UPDATE loop with
// ack timeout/retry, backpressured issue and a registered next-PC command.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [XLEN-1:0]   PC_RST    = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, UPDATE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retry_q, retry_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [6:0]        op_q, op_d;
  logic [19:0]       imm_q, imm_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   pcval_q, pcval_d;
  logic              req_c;
  logic              ack_hit_c;
  logic              hs_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (ack_hit_c) state_d = ISSUE;
      ISSUE:  if (hs_c) state_d = UPDATE;
      UPDATE: state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Request is withdrawn for the single retry cycle after a timeout.
  always_comb begin
    req_c     = 1'b0;
    ack_hit_c = 1'b0;
    hs_c      = 1'b0;
    if (state_q == FETCH && !retry_q) req_c = 1'b1;
    if (req_c && bus.imem_ack) ack_hit_c = 1'b1;
    if (state_q == ISSUE && bus.ready) hs_c = 1'b1;
  end

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = pc_q;
  assign bus.valid     = valid_q;
  assign bus.op        = op_q;
  assign bus.in        = imm_q;
  assign bus.rd        = rd_q;
  assign bus.pcvalue   = pcval_q;
  assign bus.fetch_err = err_q;

  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    wait_d  = wait_q;
    retry_d = 1'b0;
    err_d   = err_q;
    valid_d = valid_q;
    op_d    = op_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    pcval_d = pcval_q;
    unique case (state_q)
      FETCH: begin
        if (ack_hit_c) begin
          op_d    = bus.imem_data[6:0];
          rd_d    = bus.imem_data[11:7];
          imm_d   = bus.imem_data[31:12];
          pcval_d = pc_q;
          valid_d = 1'b1;
          wait_d  = '0;
        end else if (req_c) begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            retry_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ISSUE: begin
        // Next PC is resolved at the handshake and committed in UPDATE.
        if (hs_c) begin
          valid_d = 1'b0;
          case (bus.pcop)
            2'b01:   npc_d = bus.target & 32'hFFFF_FFFC;
            2'b10:   npc_d = pc_q;
            default: npc_d = pc_q + 32'd4;
          endcase
        end
      end
      UPDATE: pc_d = npc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= PC_RST;
      npc_q   <= PC_RST;
      wait_q  <= '0;
      retry_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      pcval_q <= '0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      pcval_q <= pcval_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// timeout and asynchronous-reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] D1 = 32'hC000_1097;  // op 17, imm C0001, rd 1
  localparam logic [31:0] D2 = 32'hABCD_E2B7;  // op 37, imm ABCDE, rd 5

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_unit_if bus ();
  fetch_unit_if bus_z ();

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  fetch_unit dut_z (
    .clk(clk), .rst(rst), .bus(bus_z)
  );

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic [1:0]  pcop;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [6:0]  op;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic ack, logic [31:0] data, logic ready, logic [1:0] pcop,
                              logic [31:0] target, logic req, logic [31:0] addr, logic valid,
                              logic [6:0] op, logic [19:0] imm, logic [4:0] rd, logic [31:0] pc);
    vec_t v;
    v.ack = ack; v.data = data; v.ready = ready; v.pcop = pcop; v.target = target;
    v.req = req; v.addr = addr; v.valid = valid; v.op = op; v.imm = imm; v.rd = rd; v.pc = pc;
    return v;
  endfunction

  task automatic chk_state(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic err);
    chk({tag, ".req"},   32'(bus.imem_req),  32'(req));
    chk({tag, ".addr"},  bus.imem_addr,      addr);
    chk({tag, ".valid"}, 32'(bus.valid),     32'(valid));
    chk({tag, ".err"},   32'(bus.fetch_err), 32'(err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_data = '0; bus.ready = 1'b0; bus.pcop = 2'b00; bus.target = '0;
    bus_z.imem_ack = 1'b1; bus_z.imem_data = D1; bus_z.ready = 1'b1;
    bus_z.pcop = 2'b00; bus_z.target = '0;

    vecs.push_back(mk(1, D1, 0, 2'd0, 32'h0,         1, 32'hFFFF_FFFC, 0, 7'h00, 20'h00000, 5'd0, 32'h0));
    vecs.push_back(mk(1, D1, 0, 2'd0, 32'h0,         0, 32'hFFFF_FFFC, 1, 7'h17, 20'hC0001, 5'd1, 32'hFFFF_FFFC));
    vecs.push_back(mk(1, D2, 1, 2'd0, 32'h0,         0, 32'hFFFF_FFFC, 0, 7'h17, 20'hC0001, 5'd1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0,  0, 2'd0, 32'h0,         1, 32'h0000_0000, 0, 7'h17, 20'hC0001, 5'd1, 32'hFFFF_FFFC));
    vecs.push_back(mk(1, D2, 0, 2'd1, 32'h1234_5678, 0, 32'h0000_0000, 1, 7'h37, 20'hABCDE, 5'd5, 32'h0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, D1, 0, 2'd1, 32'h1234_5678, 0, 32'h0000_0000, 1, 7'h37, 20'hABCDE, 5'd5, 32'h0));
    vecs.push_back(mk(0, 0,  1, 2'd0, 32'h1234_5678, 0, 32'h0000_0000, 0, 7'h37, 20'hABCDE, 5'd5, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'd1, 32'hFFFF_FFF0, 1, 32'h0000_0004, 0, 7'h37, 20'hABCDE, 5'd5, 32'h0));
    vecs.push_back(mk(1, D1, 0, 2'd0, 32'h0,         0, 32'h0000_0004, 1, 7'h17, 20'hC0001, 5'd1, 32'h4));
    vecs.push_back(mk(0, 0,  1, 2'd1, 32'h4000_0003, 0, 32'h0000_0004, 0, 7'h17, 20'hC0001, 5'd1, 32'h4));
    vecs.push_back(mk(0, 0,  0, 2'd0, 32'h0,         1, 32'h4000_0000, 0, 7'h17, 20'hC0001, 5'd1, 32'h4));
    vecs.push_back(mk(1, D2, 0, 2'd0, 32'h0,         0, 32'h4000_0000, 1, 7'h37, 20'hABCDE, 5'd5, 32'h4000_0000));
    vecs.push_back(mk(0, 0,  1, 2'd2, 32'h0,         0, 32'h4000_0000, 0, 7'h37, 20'hABCDE, 5'd5, 32'h4000_0000));
    vecs.push_back(mk(0, 0,  0, 2'd0, 32'h0,         1, 32'h4000_0000, 0, 7'h37, 20'hABCDE, 5'd5, 32'h4000_0000));
    vecs.push_back(mk(1, D1, 0, 2'd0, 32'h0,         0, 32'h4000_0000, 1, 7'h17, 20'hC0001, 5'd1, 32'h4000_0000));
    vecs.push_back(mk(0, 0,  1, 2'd3, 32'h0,         0, 32'h4000_0000, 0, 7'h17, 20'hC0001, 5'd1, 32'h4000_0000));
    vecs.push_back(mk(0, 0,  0, 2'd0, 32'h0,         1, 32'h4000_0004, 0, 7'h17, 20'hC0001, 5'd1, 32'h4000_0000));

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("reset.op", 32'(bus.op), 32'h0);
    chk("reset.in", 32'(bus.in), 32'h0);
    chk("reset.rd", 32'(bus.rd), 32'h0);
    chk("reset.pcvalue", bus.pcvalue, 32'h0);
    chk("reset_z.addr", bus_z.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table rows; the free-running RESET_PC=0 instance issues 0,4,8 on rows 1,4,7.
    for (int i = 0; i < vecs.size(); i++) begin
      bus.imem_ack = vecs[i].ack; bus.imem_data = vecs[i].data; bus.ready = vecs[i].ready;
      bus.pcop = vecs[i].pcop; bus.target = vecs[i].target;
      step();
      chk_state($sformatf("row%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid, 1'b0);
      chk($sformatf("row%0d.op", i), 32'(bus.op), 32'(vecs[i].op));
      chk($sformatf("row%0d.in", i), 32'(bus.in), 32'(vecs[i].imm));
      chk($sformatf("row%0d.rd", i), 32'(bus.rd), 32'(vecs[i].rd));
      chk($sformatf("row%0d.pcvalue", i), bus.pcvalue, vecs[i].pc);
      if (i == 1 || i == 4 || i == 7) begin
        chk($sformatf("seq%0d.valid", i), 32'(bus_z.valid), 32'h1);
        chk($sformatf("seq%0d.pcvalue", i), bus_z.pcvalue, 32'((i - 1) / 3 * 4));
        chk($sformatf("seq%0d.op", i), 32'(bus_z.op), 32'h17);
        chk($sformatf("seq%0d.in", i), 32'(bus_z.in), 32'hC0001);
        chk($sformatf("seq%0d.rd", i), 32'(bus_z.rd), 32'h1);
      end
    end

    // Timeout: 15 unanswered request cycles, one idle cycle, then reissue.
    bus.imem_ack = 1'b0; bus.ready = 1'b0; bus.pcop = 2'b00;
    for (int k = 1; k < 15; k++) begin
      step();
      chk_state($sformatf("wait%0d", k), 1'b1, 32'h4000_0004, 1'b0, 1'b0);
    end
    step();
    chk_state("retry_gap", 1'b0, 32'h4000_0004, 1'b0, 1'b1);
    step();
    chk_state("reissue", 1'b1, 32'h4000_0004, 1'b0, 1'b1);
    bus.imem_ack = 1'b1; bus.imem_data = D2;
    step();
    chk_state("late_ack", 1'b0, 32'h4000_0004, 1'b1, 1'b1);
    chk("late_ack.pcvalue", bus.pcvalue, 32'h4000_0004);
    chk("late_ack.op", 32'(bus.op), 32'h37);

    // Asynchronous reset while an instruction is being presented.
    #3;
    rst = 1'b1;
    #1;
    chk_state("rst_issue", 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("rst_issue.pcvalue", bus.pcvalue, 32'h0);
    chk("rst_issue.op", 32'(bus.op), 32'h0);
    bus.ready = 1'b1; bus.imem_ack = 1'b1;
    step();
    chk_state("rst_held", 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.ready = 1'b0; bus.imem_ack = 1'b0;
    #1;
    chk_state("rst_idle", 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    chk_state("rst_refetch", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);

    // Asynchronous reset while a request is outstanding.
    #3;
    rst = 1'b1;
    #1;
    chk_state("rst_fetch", 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_state("rst_fetch2", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
